// File: rtl/game_pkg.sv
// Shared definitions for the rhythm-game flow controller and its selector blocks.
package game_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    MAIN_MENU = 3'd0,
    DIFF_SEL  = 3'd1,
    SONG_SEL  = 3'd2,
    GAMEPLAY  = 3'd3,
    RESULTS   = 3'd4
  } game_state_e;

  localparam int DEF_NUM_DIFFICULTIES = 3;
  localparam int DEF_NUM_SONGS        = 8;

  // Bit positions inside the packed button vector; lower index = lower priority.
  localparam int NUM_BTNS  = 4;
  localparam int BTN_RIGHT = 0;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_DOWN  = 2;
  localparam int BTN_UP    = 3;

endpackage

// File: rtl/game_flow_ctrl_btn_edge_detect.sv
// Rising-edge detector for a vector of debounced, synchronised button levels.
module btn_edge_detect #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] btn,
  output logic [N-1:0] btn_edge
);

  logic [N-1:0] prev_q;
  logic [N-1:0] prev_d;

  always_comb begin
    prev_d = btn;
  end

  // History resets to ones so a button held through reset yields no edge.
  always_ff @(posedge clk) begin
    if (rst) prev_q <= '1;
    else     prev_q <= prev_d;
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_edge
    assign btn_edge[gi] = btn[gi] & ~prev_q[gi];
  end

endmodule

// File: rtl/game_flow_ctrl.sv
// Top-level game-flow FSM: menus, selection registers, gameplay hand-off and timed results.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int NUM_DIFFICULTIES   = DEF_NUM_DIFFICULTIES,
  parameter int NUM_SONGS          = DEF_NUM_SONGS,
  parameter int RESULT_HOLD_CYCLES = 100000000
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            btn_up,
  input  logic                            btn_down,
  input  logic                            btn_left,
  input  logic                            btn_right,
  input  logic                            game_over,
  output logic [STATE_W-1:0]              state,
  output logic [$clog2(NUM_DIFFICULTIES)-1:0] difficulty,
  output logic [$clog2(NUM_SONGS)-1:0]    selected_song,
  output logic                            difficulty_sel_en,
  output logic                            song_sel_en,
  output logic                            gameplay_en,
  output logic                            results_en,
  output logic                            game_start
);

  localparam int DIFF_W = $clog2(NUM_DIFFICULTIES);
  localparam int SONG_W = $clog2(NUM_SONGS);
  localparam int CNT_W  = $clog2(RESULT_HOLD_CYCLES);

  logic [NUM_BTNS-1:0] btn_vec;
  logic [NUM_BTNS-1:0] btn_edge;
  logic                any_edge;

  logic [STATE_W-1:0] state_q, state_d;
  logic [DIFF_W-1:0]  diff_q, diff_d;
  logic [SONG_W-1:0]  song_q, song_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               diff_en_q, diff_en_d;
  logic               song_en_q, song_en_d;
  logic               play_en_q, play_en_d;
  logic               res_en_q, res_en_d;
  logic               start_q, start_d;

  assign btn_vec = {btn_up, btn_down, btn_left, btn_right};

  btn_edge_detect #(.N(NUM_BTNS)) u_btn_edge (
    .clk      (clk),
    .rst      (rst),
    .btn      (btn_vec),
    .btn_edge (btn_edge)
  );

  assign any_edge = |btn_edge;

  always_comb begin
    state_d = state_q;
    diff_d  = diff_q;
    song_d  = song_q;
    cnt_d   = cnt_q;
    case (state_q)
      MAIN_MENU: if (any_edge) state_d = DIFF_SEL;
      DIFF_SEL: begin
        if (btn_edge[BTN_UP])
          state_d = MAIN_MENU;
        else if (btn_edge[BTN_DOWN])
          state_d = SONG_SEL;
        else if (btn_edge[BTN_LEFT])
          diff_d = (diff_q == '0) ? DIFF_W'(NUM_DIFFICULTIES - 1) : diff_q - DIFF_W'(1);
        else if (btn_edge[BTN_RIGHT])
          diff_d = (diff_q == DIFF_W'(NUM_DIFFICULTIES - 1)) ? '0 : diff_q + DIFF_W'(1);
      end
      SONG_SEL: begin
        if (btn_edge[BTN_UP])
          state_d = DIFF_SEL;
        else if (btn_edge[BTN_DOWN])
          state_d = GAMEPLAY;
        else if (btn_edge[BTN_LEFT])
          song_d = (song_q == '0) ? SONG_W'(NUM_SONGS - 1) : song_q - SONG_W'(1);
        else if (btn_edge[BTN_RIGHT])
          song_d = (song_q == SONG_W'(NUM_SONGS - 1)) ? '0 : song_q + SONG_W'(1);
      end
      GAMEPLAY: begin
        if (game_over) begin
          state_d = RESULTS;
          cnt_d   = CNT_W'(RESULT_HOLD_CYCLES - 1);
        end
      end
      RESULTS: begin
        // Counter loaded with HOLD-1 on entry, so zero marks the last results cycle.
        if (any_edge || cnt_q == '0) state_d = SONG_SEL;
        else                         cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = MAIN_MENU;
    endcase

    diff_en_d = (state_d == DIFF_SEL);
    song_en_d = (state_d == SONG_SEL);
    play_en_d = (state_d == GAMEPLAY);
    res_en_d  = (state_d == RESULTS);
    start_d   = (state_q == SONG_SEL) && (state_d == GAMEPLAY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= MAIN_MENU;
      diff_q    <= '0;
      song_q    <= '0;
      cnt_q     <= '0;
      diff_en_q <= 1'b0;
      song_en_q <= 1'b0;
      play_en_q <= 1'b0;
      res_en_q  <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      diff_q    <= diff_d;
      song_q    <= song_d;
      cnt_q     <= cnt_d;
      diff_en_q <= diff_en_d;
      song_en_q <= song_en_d;
      play_en_q <= play_en_d;
      res_en_q  <= res_en_d;
      start_q   <= start_d;
    end
  end

  assign state             = state_q;
  assign difficulty        = diff_q;
  assign selected_song     = song_q;
  assign difficulty_sel_en = diff_en_q;
  assign song_sel_en       = song_en_q;
  assign gameplay_en       = play_en_q;
  assign results_en        = res_en_q;
  assign game_start        = start_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Self-checking bench for game_flow_ctrl: behavioural model feeds a scoreboard, plus scenario checks.
module tb_game_flow_ctrl;

  localparam int ND   = 3;
  localparam int NS   = 5;
  localparam int HOLD = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic       game_over = 1'b0;
  logic [2:0] state;
  logic [1:0] difficulty;
  logic [2:0] selected_song;
  logic       difficulty_sel_en, song_sel_en, gameplay_en, results_en, game_start;

  always #5 clk = ~clk;

  game_flow_ctrl #(
    .NUM_DIFFICULTIES   (ND),
    .NUM_SONGS          (NS),
    .RESULT_HOLD_CYCLES (HOLD)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .btn_up            (btn_up),
    .btn_down          (btn_down),
    .btn_left          (btn_left),
    .btn_right         (btn_right),
    .game_over         (game_over),
    .state             (state),
    .difficulty        (difficulty),
    .selected_song     (selected_song),
    .difficulty_sel_en (difficulty_sel_en),
    .song_sel_en       (song_sel_en),
    .gameplay_en       (gameplay_en),
    .results_en        (results_en),
    .game_start        (game_start)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  logic [12:0] sb[$];

  int         m_state = 0, m_diff = 0, m_song = 0, m_cnt = 0;
  logic [3:0] m_prev = 4'hF;

  function automatic logic [12:0] observed();
    return {state, difficulty, selected_song, difficulty_sel_en, song_sel_en,
            gameplay_en, results_en, game_start};
  endfunction

  // Scoreboard drain: one expected entry per driven cycle, compared after the edge.
  always @(posedge clk) begin : monitor
    logic [12:0] exp_v;
    logic [12:0] act_v;
    #1;
    if (sb.size() > 0) begin
      exp_v = sb.pop_front();
      act_v = observed();
      tests_run++;
      if (act_v !== exp_v) begin
        tests_failed++;
        $display("FAIL scoreboard t=%0t got %b want %b (state diff song de se ge re gs)",
                 $time, act_v, exp_v);
      end
    end
  end

  // b = {up, down, left, right}; drives one cycle and pushes the model's prediction.
  task automatic step(input logic [3:0] b, input logic go, input logic r);
    logic [3:0] e;
    int         ns;
    logic       gs;
    @(negedge clk);
    {btn_up, btn_down, btn_left, btn_right} = b;
    game_over = go;
    rst       = r;
    gs        = 1'b0;
    if (r) begin
      m_state = 0; m_diff = 0; m_song = 0; m_cnt = 0; m_prev = 4'hF;
    end else begin
      e      = b & ~m_prev;
      m_prev = b;
      ns     = m_state;
      case (m_state)
        0: if (e != 4'b0) ns = 1;
        1: begin
          if (e[3])      ns = 0;
          else if (e[2]) ns = 2;
          else if (e[1]) m_diff = (m_diff + ND - 1) % ND;
          else if (e[0]) m_diff = (m_diff + 1) % ND;
        end
        2: begin
          if (e[3])      ns = 1;
          else if (e[2]) begin ns = 3; gs = 1'b1; end
          else if (e[1]) m_song = (m_song + NS - 1) % NS;
          else if (e[0]) m_song = (m_song + 1) % NS;
        end
        3: if (go) begin ns = 4; m_cnt = HOLD - 1; end
        4: begin
          if (e != 4'b0 || m_cnt == 0) ns = 2;
          else m_cnt = m_cnt - 1;
        end
        default: ns = 0;
      endcase
      m_state = ns;
    end
    sb.push_back({3'(m_state), 2'(m_diff), 3'(m_song), (m_state == 1), (m_state == 2),
                  (m_state == 3), (m_state == 4), gs});
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic press(input logic [3:0] b);
    step(4'b0000, 1'b0, 1'b0);
    step(b, 1'b0, 1'b0);
    settle();
  endtask

  task automatic test_reset();
    repeat (3) step(4'b0100, 1'b0, 1'b1);
    settle();
    tests_run++;
    if (observed() !== 13'b0) begin
      tests_failed++;
      $display("FAIL reset_values got %b want 0", observed());
    end
    repeat (5) step(4'b0100, 1'b0, 1'b0);
    settle();
    tests_run++;
    if (state !== 3'd0) begin
      tests_failed++;
      $display("FAIL held_through_reset state got %0d want 0", state);
    end
    press(4'b0100);
    tests_run++;
    if (state !== 3'd1 || difficulty_sel_en !== 1'b1) begin
      tests_failed++;
      $display("FAIL repress_to_diff state got %0d en %b want 1 en 1", state, difficulty_sel_en);
    end
  endtask

  task automatic test_diff_wrap();
    int exp_r[4] = '{1, 2, 0, 1};
    int exp_l[2] = '{0, 2};
    for (int i = 0; i < 4; i++) begin
      press(4'b0001);
      tests_run++;
      if (difficulty !== 2'(exp_r[i])) begin
        tests_failed++;
        $display("FAIL diff_right[%0d] got %0d want %0d", i, difficulty, exp_r[i]);
      end
    end
    for (int i = 0; i < 2; i++) begin
      press(4'b0010);
      tests_run++;
      if (difficulty !== 2'(exp_l[i])) begin
        tests_failed++;
        $display("FAIL diff_left[%0d] got %0d want %0d", i, difficulty, exp_l[i]);
      end
    end
  endtask

  task automatic test_song_wrap();
    int exp_s[3] = '{4, 0, 1};
    press(4'b0100);
    tests_run++;
    if (state !== 3'd2 || selected_song !== 3'd0) begin
      tests_failed++;
      $display("FAIL enter_song_sel state %0d song %0d want 2 0", state, selected_song);
    end
    for (int i = 0; i < 3; i++) begin
      press(i == 0 ? 4'b0010 : 4'b0001);
      tests_run++;
      if (selected_song !== 3'(exp_s[i])) begin
        tests_failed++;
        $display("FAIL song_wrap[%0d] got %0d want %0d", i, selected_song, exp_s[i]);
      end
    end
    press(4'b1101);
    tests_run++;
    if (state !== 3'd1 || selected_song !== 3'd1) begin
      tests_failed++;
      $display("FAIL priority_up state %0d song %0d want 1 1", state, selected_song);
    end
    press(4'b0100);
  endtask

  task automatic test_gameplay();
    press(4'b0100);
    tests_run++;
    if (state !== 3'd3 || game_start !== 1'b1 || gameplay_en !== 1'b1) begin
      tests_failed++;
      $display("FAIL enter_gameplay state %0d gs %b en %b want 3 1 1", state, game_start, gameplay_en);
    end
    step(4'b0000, 1'b0, 1'b0);
    settle();
    tests_run++;
    if (game_start !== 1'b0) begin
      tests_failed++;
      $display("FAIL game_start_pulse got %b want 0", game_start);
    end
    press(4'b0010);
    press(4'b0001);
    press(4'b1000);
    tests_run++;
    if (state !== 3'd3 || difficulty !== 2'd2 || selected_song !== 3'd1) begin
      tests_failed++;
      $display("FAIL frozen_in_play state %0d diff %0d song %0d want 3 2 1",
               state, difficulty, selected_song);
    end
  endtask

  task automatic test_results_timeout();
    int hi_cycles;
    step(4'b0000, 1'b1, 1'b0);
    settle();
    hi_cycles = (results_en === 1'b1) ? 1 : 0;
    // game_over stays high to show it cannot re-enter RESULTS.
    for (int i = 0; i < 3 * HOLD; i++) begin
      step(4'b0000, 1'b1, 1'b0);
      settle();
      if (results_en === 1'b1) hi_cycles++;
      else break;
    end
    tests_run++;
    if (hi_cycles != HOLD || state !== 3'd2) begin
      tests_failed++;
      $display("FAIL results_timeout cycles %0d state %0d want %0d 2", hi_cycles, state, HOLD);
    end
    step(4'b0000, 1'b0, 1'b0);
  endtask

  task automatic test_results_early();
    press(4'b0100);
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0010, 1'b0, 1'b0);
    settle();
    tests_run++;
    if (state !== 3'd2 || selected_song !== 3'd1 || results_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL results_early state %0d song %0d ren %b want 2 1 0",
               state, selected_song, results_en);
    end
  endtask

  task automatic test_reset_mid();
    press(4'b0100);
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0001, 1'b1, 1'b1);
    settle();
    tests_run++;
    if (observed() !== 13'b0) begin
      tests_failed++;
      $display("FAIL reset_in_results got %b want 0", observed());
    end
    press(4'b0001);
    press(4'b0100);
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0100, 1'b0, 1'b1);
    settle();
    tests_run++;
    if (observed() !== 13'b0) begin
      tests_failed++;
      $display("FAIL reset_blocks_start got %b want 0", observed());
    end
    press(4'b0001);
    press(4'b0100);
    press(4'b0100);
    step(4'b0000, 1'b0, 1'b1);
    settle();
    tests_run++;
    if (observed() !== 13'b0) begin
      tests_failed++;
      $display("FAIL reset_in_gameplay got %b want 0", observed());
    end
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    settle();
    tests_run++;
    if (state !== 3'd0) begin
      tests_failed++;
      $display("FAIL game_over_in_menu state %0d want 0", state);
    end
    step(4'b0000, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_diff_wrap();
    test_song_wrap();
    test_gameplay();
    test_results_timeout();
    test_results_early();
    test_reset_mid();
    repeat (2) settle();
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain left %0d want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
